// File: rtl/ccd_timing_generator.sv
// ccd_timing_generator: linear-CCD clock sequencer (phi_p / phi_r / phi_l1 / phi_l2).
// Sequence: SHIFT (N_PIXELS four-quarter periods), optional HOLD, PULSE, then SHIFT again.
// Single-shot mode returns to IDLE after SHIFT; continuous mode loops.
// Optional build macro CCD_TIMING_SAMPLE_STROBE_EN adds o_sample, an ADC strobe at the end of q1.
// All outputs are registered. Each one lags the internal state by one clock.
module ccd_timing_generator #(
    parameter int unsigned N_PIXELS     = 2052,
    parameter int unsigned PHASE_CYCLES = 1,
    parameter int unsigned PULSE_CYCLES = 18,
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned PIX_W        = 12
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_enable,
    input  logic             i_mode,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_t_int,
    output logic             o_phi_p,
    output logic             o_phi_r,
    output logic             o_phi_l1,
    output logic             o_phi_l2,
    output logic             o_busy,
    output logic             o_frame_done,
    output logic [PIX_W-1:0] o_pixel_idx
`ifdef CCD_TIMING_SAMPLE_STROBE_EN
    ,
    output logic             o_sample
`endif
);

    localparam int unsigned PH_W = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
    localparam int unsigned PU_W = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2,
        PULSE = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [PH_W-1:0]   ph_cnt;
    logic [1:0]        quarter;
    logic [PIX_W-1:0]  pix_cnt;
    logic [PU_W-1:0]   pulse_cnt;
    logic [CNT_W-1:0]  int_cnt;
    logic [CNT_W-1:0]  int_inc;
    logic [CNT_W-1:0]  t_lat;
    logic              clr;
    logic              ph_last;
    logic              period_last;
    logic              line_last;
    logic              hold_done;
    logic              pulse_last;
    logic              enter_shift;

    logic              phi_p_d, phi_r_d, phi_l1_d, phi_l2_d, busy_d, done_d;
    logic [PIX_W-1:0]  pix_d;
`ifdef CCD_TIMING_SAMPLE_STROBE_EN
    logic              sample_d;
`endif

    assign clr         = i_rst | ~i_enable;
    assign ph_last     = (ph_cnt == PH_W'(PHASE_CYCLES - 1));
    assign period_last = ph_last && (quarter == 2'd3);
    assign line_last   = period_last && (pix_cnt == PIX_W'(N_PIXELS - 1));
    // Saturating increment. HOLD ends on the cycle whose incremented count reaches
    // t_lat, so that SHIFT plus HOLD spans t_lat clocks (never fewer than one HOLD clock).
    assign int_inc     = (int_cnt == '1) ? int_cnt : int_cnt + CNT_W'(1);
    assign hold_done   = (int_inc >= t_lat);
    assign pulse_last  = (pulse_cnt == PU_W'(PULSE_CYCLES - 1));
    assign enter_shift = (state_nxt == SHIFT) && (state != SHIFT);

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (i_start || !i_mode) state_nxt = SHIFT;
            SHIFT: if (line_last)          state_nxt = i_mode ? IDLE : HOLD;
            HOLD:  if (hold_done)          state_nxt = PULSE;
            PULSE: if (pulse_last)         state_nxt = SHIFT;
            default:                       state_nxt = IDLE;
        endcase
    end

    // State register, shift counters, integration counter and t_int latch
    always_ff @(posedge i_clk) begin
        if (clr) begin
            state     <= IDLE;
            ph_cnt    <= '0;
            quarter   <= '0;
            pix_cnt   <= '0;
            pulse_cnt <= '0;
            int_cnt   <= '0;
            t_lat     <= '0;
        end else begin
            state <= state_nxt;

            if (enter_shift) begin
                t_lat   <= i_t_int;
                int_cnt <= '0;
                ph_cnt  <= '0;
                quarter <= '0;
                pix_cnt <= '0;
            end else begin
                if (state == SHIFT || state == HOLD)
                    int_cnt <= int_inc;
                if (state == SHIFT) begin
                    ph_cnt <= ph_last ? '0 : ph_cnt + PH_W'(1);
                    if (ph_last)
                        quarter <= quarter + 2'd1;
                    if (period_last)
                        pix_cnt <= pix_cnt + PIX_W'(1);
                end
            end

            pulse_cnt <= (state == PULSE) ? pulse_cnt + PU_W'(1) : '0;
        end
    end

    // Output decode from current state and phase
    always_comb begin
        phi_p_d  = 1'b0;
        phi_r_d  = 1'b0;
        phi_l1_d = 1'b0;
        phi_l2_d = 1'b0;
        busy_d   = (state != IDLE);
        done_d   = 1'b0;
        pix_d    = '0;
`ifdef CCD_TIMING_SAMPLE_STROBE_EN
        sample_d = 1'b0;
`endif
        case (state)
            SHIFT: begin
                phi_r_d  = (quarter == 2'd0);
                phi_l2_d = ~quarter[1];
                phi_l1_d = quarter[1];
                pix_d    = pix_cnt;
                done_d   = line_last;
`ifdef CCD_TIMING_SAMPLE_STROBE_EN
                sample_d = (quarter == 2'd1) && ph_last;
`endif
            end
            PULSE: begin
                phi_p_d  = 1'b1;
                phi_r_d  = 1'b1;
                phi_l2_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Output registers
    always_ff @(posedge i_clk) begin
        if (clr) begin
            o_phi_p      <= 1'b0;
            o_phi_r      <= 1'b0;
            o_phi_l1     <= 1'b0;
            o_phi_l2     <= 1'b0;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b0;
            o_pixel_idx  <= '0;
`ifdef CCD_TIMING_SAMPLE_STROBE_EN
            o_sample     <= 1'b0;
`endif
        end else begin
            o_phi_p      <= phi_p_d;
            o_phi_r      <= phi_r_d;
            o_phi_l1     <= phi_l1_d;
            o_phi_l2     <= phi_l2_d;
            o_busy       <= busy_d;
            o_frame_done <= done_d;
            o_pixel_idx  <= pix_d;
`ifdef CCD_TIMING_SAMPLE_STROBE_EN
            o_sample     <= sample_d;
`endif
        end
    end

endmodule

// File: tb/tb_ccd_timing_generator.sv
// tb_ccd_timing_generator: random and directed stimulus for two shared-input instances
// (PHASE_CYCLES 1 and 3), each compared every clock against a timeline reference model.
module tb_ccd_timing_generator;

    logic        clk = 1'b0;
    logic        rst, en, mode, start;
    logic [31:0] t_int;

    logic        a_p, a_r, a_l1, a_l2, a_busy, a_done;
    logic [11:0] a_pix;
    logic        b_p, b_r, b_l1, b_l2, b_busy, b_done;
    logic [11:0] b_pix;
`ifdef CCD_TIMING_SAMPLE_STROBE_EN
    logic        a_smp, b_smp;
`endif

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int st;    // 0 idle, 1 shift, 2 hold, 3 pulse
        int t;     // clocks spent in current state
        int tlat;
    } mdl_t;

    mdl_t        ma, mb;
    logic [17:0] exp_a, exp_b;
    logic        exp_sa, exp_sb;

    always #5 clk = ~clk;

    ccd_timing_generator #(
        .N_PIXELS(4), .PHASE_CYCLES(1), .PULSE_CYCLES(3), .CNT_W(32), .PIX_W(12)
    ) dut_a (
        .i_clk(clk), .i_rst(rst), .i_enable(en), .i_mode(mode), .i_start(start),
        .i_t_int(t_int), .o_phi_p(a_p), .o_phi_r(a_r), .o_phi_l1(a_l1),
        .o_phi_l2(a_l2), .o_busy(a_busy), .o_frame_done(a_done), .o_pixel_idx(a_pix)
`ifdef CCD_TIMING_SAMPLE_STROBE_EN
        , .o_sample(a_smp)
`endif
    );

    ccd_timing_generator #(
        .N_PIXELS(4), .PHASE_CYCLES(3), .PULSE_CYCLES(2), .CNT_W(32), .PIX_W(12)
    ) dut_b (
        .i_clk(clk), .i_rst(rst), .i_enable(en), .i_mode(mode), .i_start(start),
        .i_t_int(t_int), .o_phi_p(b_p), .o_phi_r(b_r), .o_phi_l1(b_l1),
        .o_phi_l2(b_l2), .o_busy(b_busy), .o_frame_done(b_done), .o_pixel_idx(b_pix)
`ifdef CCD_TIMING_SAMPLE_STROBE_EN
        , .o_sample(b_smp)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // Expected registered outputs {p,r,l1,l2,busy,done,pix} for a model state.
    function automatic logic [17:0] mdl_out(input mdl_t m, input int n, input int pc,
                                            output logic smp);
        int per, ph, q, pix;
        logic p, r, l1, l2, busy, done;
        p = 0; r = 0; l1 = 0; l2 = 0; busy = (m.st != 0); done = 0; pix = 0; smp = 0;
        per = 4 * pc;
        if (m.st == 1) begin
            ph   = m.t % per;
            pix  = m.t / per;
            q    = ph / pc;
            r    = (q == 0);
            l2   = (q < 2);
            l1   = (q >= 2);
            done = (m.t == n * per - 1);
            smp  = (ph == 2 * pc - 1);
        end else if (m.st == 3) begin
            p = 1; r = 1; l2 = 1;
        end
        return {p, r, l1, l2, busy, done, 12'(pix)};
    endfunction

    function automatic mdl_t mdl_next(input mdl_t m, input int n, input int pc, input int pw,
                                      input logic st_req, input logic md, input int tin);
        mdl_t nx;
        int line, hold_len;
        line     = n * 4 * pc;
        hold_len = (m.tlat > line + 1) ? m.tlat - line : 1;
        nx       = m;
        nx.t     = m.t + 1;
        case (m.st)
            0: if (st_req || !md) nx = '{1, 0, tin};
            1: if (m.t == line - 1) nx = '{md ? 0 : 2, 0, m.tlat};
            2: if (m.t == hold_len - 1) nx = '{3, 0, m.tlat};
            default: if (m.t == pw - 1) nx = '{1, 0, tin};
        endcase
        return nx;
    endfunction

    // One clock: advance models with current inputs, let the edge happen, compare.
    task automatic tick();
        if (rst || !en) begin
            exp_a = '0; exp_b = '0; exp_sa = 0; exp_sb = 0;
            ma = '{0, 0, 0};
            mb = '{0, 0, 0};
        end else begin
            exp_a = mdl_out(ma, 4, 1, exp_sa);
            ma    = mdl_next(ma, 4, 1, 3, start, mode, int'(t_int));
            exp_b = mdl_out(mb, 4, 3, exp_sb);
            mb    = mdl_next(mb, 4, 3, 2, start, mode, int'(t_int));
        end
        @(posedge clk);
        #1;
        check("dut_a_outputs", 32'({a_p, a_r, a_l1, a_l2, a_busy, a_done, a_pix}), 32'(exp_a));
        check("dut_b_outputs", 32'({b_p, b_r, b_l1, b_l2, b_busy, b_done, b_pix}), 32'(exp_b));
        check("dut_a_exclusive", 32'({a_l1 & a_l2, a_p & a_l1}), 32'(0));
        check("dut_b_exclusive", 32'({b_l1 & b_l2, b_p & b_l1}), 32'(0));
`ifdef CCD_TIMING_SAMPLE_STROBE_EN
        check("dut_a_sample", 32'(a_smp), 32'(exp_sa));
        check("dut_b_sample", 32'(b_smp), 32'(exp_sb));
`endif
    endtask

    initial begin
        ma = '{0, 0, 0};
        mb = '{0, 0, 0};
        rst = 1; en = 1; mode = 1; start = 0; t_int = 32'd0;
        #1;
        for (int unsigned i = 0; i < 3; i++) tick();
        rst = 0;
        for (int unsigned i = 0; i < 3; i++) tick();

        // Single-shot line, with a stray start mid-line
        start = 1; tick(); start = 0;
        for (int unsigned i = 0; i < 6; i++) tick();
        start = 1; tick(); start = 0;
        for (int unsigned i = 0; i < 60; i++) tick();

        // Continuous, long integration then short integration
        t_int = 32'd40; mode = 0;
        for (int unsigned i = 0; i < 250; i++) tick();
        t_int = 32'd5;
        for (int unsigned i = 0; i < 150; i++) tick();

        // Mode switched to single-shot mid-line; takes effect at line end
        mode = 1;
        for (int unsigned i = 0; i < 80; i++) tick();

        // Reset mid-line
        mode = 0;
        for (int unsigned i = 0; i < 10; i++) tick();
        rst = 1; tick(); rst = 0;
        for (int unsigned i = 0; i < 20; i++) tick();

        // Randomized phase
        for (int unsigned i = 0; i < 4000; i++) begin
            rst   = ($urandom_range(0, 199) == 0);
            en    = ($urandom_range(0, 149) != 0);
            start = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 59) == 0) mode = ~mode;
            if ($urandom_range(0, 9) == 0) t_int = 32'($urandom_range(0, 80));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
